// File: rtl/chacha20_word_packer.sv
// Byte-to-word packer: packs a framed 8-bit stream little-endian into 32-bit words
// with zero padding of the final partial word. Optional out_keep port: CHACHA20_PACKER_KEEP_EN.
module chacha20_word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready,
  output logic        done
`ifdef CHACHA20_PACKER_KEEP_EN
  ,
  output logic [3:0]  out_keep
`endif
);

  logic [1:0]  idx;
  logic [23:0] acc;
  logic        byte_fire;
  logic        word_fire;
  logic        completes;

  // Lanes below pos come from the accumulator, lane pos gets the new byte, lanes above stay zero.
  function automatic logic [31:0] pack_word(input logic [23:0] lanes,
                                            input logic [7:0]  new_byte,
                                            input logic [1:0]  pos);
    logic [31:0] w;
    w = 32'd0;
    for (int i = 0; i < 3; i++) begin
      if (i < int'(pos)) w[8*i +: 8] = lanes[8*i +: 8];
    end
    w[8*pos +: 8] = new_byte;
    return w;
  endfunction

`ifdef CHACHA20_PACKER_KEEP_EN
  function automatic logic [3:0] keep_mask(input logic [1:0] pos);
    logic [3:0] k;
    case (pos)
      2'd0:    k = 4'b0001;
      2'd1:    k = 4'b0011;
      2'd2:    k = 4'b0111;
      default: k = 4'b1111;
    endcase
    return k;
  endfunction
`endif

  assign in_ready  = !out_valid || out_ready;
  assign byte_fire = in_valid && in_ready;
  assign word_fire = out_valid && out_ready;
  assign completes = byte_fire && (in_last || idx == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= 2'd0;
      acc <= 24'd0;
    end else if (byte_fire) begin
      if (completes) begin
        idx <= 2'd0;
        acc <= 24'd0;
      end else begin
        idx <= idx + 2'd1;
        case (idx)
          2'd0:    acc[7:0]   <= in_data;
          2'd1:    acc[15:8]  <= in_data;
          default: acc[23:16] <= in_data;
        endcase
      end
    end
  end

  // A completing byte can only be accepted when the output register is empty or draining,
  // so loading it here also covers the back-to-back reload case.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= 32'd0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
`ifdef CHACHA20_PACKER_KEEP_EN
      out_keep  <= 4'd0;
`endif
    end else if (completes) begin
      out_data  <= pack_word(acc, in_data, idx);
      out_last  <= in_last;
      out_valid <= 1'b1;
`ifdef CHACHA20_PACKER_KEEP_EN
      out_keep  <= keep_mask(idx);
`endif
    end else if (word_fire) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done <= 1'b0;
    else        done <= word_fire && out_last;
  end

endmodule

// File: doc/chacha20_word_packer.md
# chacha20_word_packer

Byte-to-word stream packer that sits upstream of the ChaCha20 cipher core and drives its 32-bit data stream (data/valid/last/ready). It takes an 8-bit byte stream with frame delimiting, packs bytes little-endian into 32-bit words, and zero-pads the final partial word. On the output side it is the transmitting end of the cipher's word-stream interface. It emits a one-cycle `done` pulse when the last word of a frame is accepted downstream.

## Interface
- No parameters; widths fixed at 8-bit in, 32-bit out.
- `clk` input 1: system clock; all state updates on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_data` input 8: input byte.
- `in_valid` input 1: `in_data`/`in_last` valid.
- `in_last` input 1: byte is final byte of frame.
- `in_ready` output 1: packer accepts a byte this cycle.
- `out_data` output 32: packed word, first byte of the word in [7:0].
- `out_valid` output 1: `out_data`/`out_last` valid.
- `out_last` output 1: word is final word of frame.
- `out_ready` input 1: downstream accepts the word.
- `done` output 1: one-cycle pulse on acceptance of the `out_last` word.
- `out_keep` output 4: byte enables of `out_data`; present only with `CHACHA20_PACKER_KEEP_EN`.

## Operation
- Byte handshake: `in_valid && in_ready` at a rising edge. Word handshake: `out_valid && out_ready` at a rising edge.
- State:
  - `idx[1:0]`: next byte lane.
  - `acc[23:0]`: lanes 0–2 collected so far.
  - Output register: `out_data`, `out_last`, `out_keep`, `out_valid`.
- Accepted byte with `idx<3` and `in_last=0`: written to lane `idx`, `idx` increments, output register untouched.
- Accepted byte with `idx==3`, or with `in_last=1`, completes the word:
  - The output register loads {byte in lane `idx`, acc lanes below `idx`, zeros above}.
  - `out_last` loads `in_last`, `out_valid` goes to 1.
  - `idx` returns to 0 and `acc` clears.
- `in_ready = !out_valid || out_ready`. This is combinational and holds even when the byte would not complete a word.
- Word handshake with no completing byte in the same cycle: `out_valid` goes to 0.
- Word handshake and completing byte in the same cycle: the register reloads with the new word and `out_valid` stays 1, so there is no bubble.
- While `out_valid=1 && out_ready=0`: `out_data`, `out_last` and `out_keep` are held stable.
- `done` is registered. It is 1 for exactly the cycle after the edge where the `out_last` word handshakes.
- Empty frames are not supported; every frame ends with a valid byte carrying `in_last=1`.
- Frames pack independently. A new frame's first byte always lands in lane 0.

## Timing
- Reset values:
  - Outputs: `out_valid=0`, `out_last=0`, `out_data=0`, `out_keep=0`, `done=0`. `in_ready` reads 1, since it is derived from `out_valid=0`.
  - Internal state: `idx=0`, `acc=0`.
- Latency: completing byte accepted at edge N → word visible with `out_valid=1` after edge N.
- Throughput: 1 byte/cycle sustained when `out_ready=1`, giving one word every 4 cycles for full words.
- Asserting reset mid-frame discards partial `acc` and any pending output word. After release, the next byte starts a new word in lane 0.
- `in_ready` never depends on `in_valid` or `in_last`.

## Configuration
- Macro: `CHACHA20_PACKER_KEEP_EN`.
- Defined: `out_keep` port exists. It is registered with the word and reads 4'b0001 / 0011 / 0111 / 1111 for 1 / 2 / 3 / 4 valid bytes. It is 4'b1111 for every non-last word.
- Undefined: no `out_keep` port and no keep logic. Padding lanes still read as zero.

## Test plan
- Full words: bytes 0x00..0x07, `in_last` on 0x07, `out_ready=1` → words 0x03020100 (`out_last=0`), then 0x07060504 (`out_last=1`); `done` pulses once.
- Partial last word: bytes 0x11,0x22,0x33,0x44,0x55 with last on 0x55 → 0x44332211, then 0x00000055 with `out_last=1` (`out_keep=4'b0001` if enabled).
- Backpressure: hold `out_ready=0` while the first word is pending → `in_ready=0` and `out_data` stable for 10 cycles. Raise `out_ready` → stream resumes with no byte lost or duplicated.
- Back-to-back frames: 1-byte frame 0xAA, then 3-byte frame 0x01,0x02,0x03 → 0x000000AA (last), then 0x00030201 (last); two `done` pulses; new frame starts in lane 0.
- Reset mid-frame: two bytes accepted, then `rst_n` low for 1 cycle → all outputs at reset values. Next 4 bytes 0xDE,0xAD,0xBE,0xEF → 0xEFBEADDE.
- No-bubble reload: `out_ready=1` continuously, 12 bytes → `out_valid` high on the cycle after each 4th byte. Each word is accepted one cycle later, and the three words are contiguous with correct order.
